zorro_int_ctrl: RTL and testbench
=================================

ZORRO_INT_CTRL -- requirements
Module: zorro_int_ctrl

Interface
REQ-001 Parameter NUM_SRC, 4, number of interrupt sources, legal range 1..8.
REQ-002 Parameter BASE_MATCH, 7'h44, ADDR[23:17] value that selects the register window.
REQ-003 Parameter INT_LEVEL, 3'd2, Zorro interrupt level answered in IACK cycles.
REQ-004 Port CLK in 1: single clock; all state is updated on the rising edge.
REQ-005 Port RESET_n in 1: asynchronous, active-low reset.
REQ-006 Ports FCS_n, DS0_n, MTCR_n, READ, LOCK, configured: each in 1, Zorro cycle qualifiers; _n ports are active-low.
REQ-007 Port FC in 3: function codes.
REQ-008 Port ADDR in 23: address bits [23:1].
REQ-009 Port DIN in 8: write data.
REQ-010 Port SRC_INT_n in NUM_SRC: active-low, asynchronous interrupt requests.
REQ-011 Port INT_OE out 1: high drives the INT line low (open-drain handled at top level).
REQ-012 Ports SLAVE_n, DTACK_n: each out 1, active-low bus responses.
REQ-013 Port DOUT out 8: read data or vector.
REQ-014 Port DOE out 1: high enables the DOUT drivers.

Function
REQ-015 Each SRC_INT_n bit shall pass through a 2-flop synchroniser; pending[i] sets on any cycle where the synchronised bit is low.
REQ-016 INT_OE shall equal configured AND assigned AND |(pending & ~mask).
REQ-017 A register hit shall require configured, FCS_n low, LOCK low, ADDR[23:17]==BASE_MATCH and FC!=7; ADDR[3:2] selects the register: 0 vector, 1 mask, 2 status.
REQ-018 An IACK hit shall require FC==3'b111, READ high, ADDR[3:1]==INT_LEVEL, FCS_n low, assigned high and at least one pending&~mask bit.
REQ-019 FSM states: IDLE, REG, IACK_POLL, IACK_SLV, ACK, WAIT_END.
REQ-020 Transitions: IDLE->REG on a claimable register hit; IDLE->IACK_POLL on an IACK hit, latching winner = lowest-index pending&~mask bit.
REQ-021 Transitions: IACK_POLL->IACK_SLV when MTCR_n is low; REG and IACK_SLV go to ACK when DS0_n is low; ACK->WAIT_END unconditionally; WAIT_END->IDLE when FCS_n is high.
REQ-022 FCS_n high in any state shall force IDLE on the next edge, with no register write and no pending clear (abort).
REQ-023 SLAVE_n shall be low in REG, IACK_SLV, ACK and WAIT_END, and high otherwise.
REQ-024 DTACK_n and DOE shall be low/high respectively in ACK and WAIT_END only.
REQ-025 On entry to ACK via IACK, DOUT shall be (vector + winner) mod 256 and pending[winner] shall clear; if the source is still low on that same edge, set wins.
REQ-026 On entry to ACK via a REG write: offset 0 loads vector from DIN and sets assigned; offset 1 loads mask[NUM_SRC-1:0] from DIN; offset 2 is ignored.
REQ-027 Each REG or IACK access shall take effect exactly once per FCS_n assertion.
REQ-028 DOUT shall hold its value while DOE is high and shall be 8'h00 otherwise.

Reset
REQ-029 RESET_n low shall set: state IDLE, pending 0, synchronisers all-ones, mask 0, vector 8'h0F, assigned 0, INT_OE 0, SLAVE_n 1, DTACK_n 1, DOUT 8'h00, DOE 0.
REQ-030 Reset asserted mid-cycle shall release the bus immediately (asynchronously) and discard the in-flight write or acknowledge.

Configuration
REQ-031 Macro ZINT_STATUS_READ_EN, when defined: register reads are claimed and return, on entry to ACK, offset 0 = vector, offset 1 = zero-extended mask, offset 2 = zero-extended pending, offset 3 = 8'h00.
REQ-032 When ZINT_STATUS_READ_EN is undefined: register reads (READ high) are not claimable; the FSM stays IDLE and SLAVE_n stays high.

Verification
REQ-033 Reset; write 8'h40 at offset 0; pull SRC_INT_n[2] low -> INT_OE=1 within 3 clocks.
REQ-034 Run an IACK at level 2 with pending {1,2} and vector 8'h40 -> DOUT=8'h41 with DOE=1 and DTACK_n=0; pending[1] cleared; INT_OE stays 1 for source 2.
REQ-035 Write mask 8'h04 with only source 2 pending -> INT_OE=0; an IACK hit is not taken and SLAVE_n stays 1.
REQ-036 Deassert FCS_n while in IACK_SLV -> next state IDLE; pending unchanged; DTACK_n never goes low.
REQ-037 Hold a source low through its own acknowledge -> pending stays 1; a second IACK returns the same vector.
REQ-038 With ZINT_STATUS_READ_EN, read offset 2 with pending 4'b0101 -> DOUT=8'h05; without the macro, the same read leaves SLAVE_n=1.

Source files
------------

// File: rtl/zorro_int_ctrl.sv
// Zorro bus interrupt controller: synchronised sources, mask/vector registers, IACK responder.
// Optional macro ZINT_STATUS_READ_EN makes register reads claimable (vector/mask/pending readback).
module zorro_int_ctrl #(
  parameter int unsigned NUM_SRC    = 4,
  parameter logic [6:0]  BASE_MATCH = 7'h44,
  parameter logic [2:0]  INT_LEVEL  = 3'd2
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic               FCS_n,
  input  logic               DS0_n,
  input  logic               MTCR_n,
  input  logic               READ,
  input  logic               LOCK,
  input  logic               configured,
  input  logic [2:0]         FC,
  input  logic [23:1]        ADDR,
  input  logic [7:0]         DIN,
  input  logic [NUM_SRC-1:0] SRC_INT_n,
  output logic               INT_OE,
  output logic               SLAVE_n,
  output logic               DTACK_n,
  output logic [7:0]         DOUT,
  output logic               DOE
);

  typedef enum logic [2:0] {
    StIdle, StReg, StIackPoll, StIackSlv, StAck, StWaitEnd
  } state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, pending_q, mask_q;
  logic [7:0]         vector_q;
  logic               assigned_q;
  logic [2:0]         winner_q;
  logic [1:0]         reg_off_q;
  logic               reg_rd_q;

  logic [NUM_SRC-1:0] active, pend_clr;
  logic [2:0]         win_idx;
  logic               reg_hit, reg_claim, iack_hit, iack_ack;
  logic               unused_addr;

  assign unused_addr = ^ADDR[16:4];
  assign active      = pending_q & ~mask_q;
  assign INT_OE      = configured & assigned_q & (|active);

  assign reg_hit = configured & ~FCS_n & ~LOCK & (ADDR[23:17] == BASE_MATCH) & (FC != 3'b111);
`ifdef ZINT_STATUS_READ_EN
  assign reg_claim = reg_hit;
`else
  assign reg_claim = reg_hit & ~READ;
`endif
  assign iack_hit = (FC == 3'b111) & READ & (ADDR[3:1] == INT_LEVEL) & ~FCS_n & assigned_q &
                    (|active);
  assign iack_ack = (state_q == StIackSlv) & ~FCS_n & ~DS0_n;

  // Lowest-index unmasked pending source wins arbitration.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_clr[i] = iack_ack && (winner_q == 3'(i));
    end
  end

`ifdef ZINT_STATUS_READ_EN
  logic [7:0] mask_ext, pend_ext, rd_data;
  always_comb begin
    mask_ext = '0;
    pend_ext = '0;
    mask_ext[NUM_SRC-1:0] = mask_q;
    pend_ext[NUM_SRC-1:0] = pending_q;
    unique case (reg_off_q)
      2'd0:    rd_data = vector_q;
      2'd1:    rd_data = mask_ext;
      2'd2:    rd_data = pend_ext;
      default: rd_data = 8'h00;
    endcase
  end
`endif

  // A still-asserted source re-sets pending on the same edge that clears it.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      pending_q <= '0;
    end else begin
      sync1_q   <= SRC_INT_n;
      sync2_q   <= sync1_q;
      pending_q <= (pending_q & ~pend_clr) | ~sync2_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      vector_q   <= 8'h0F;
      assigned_q <= 1'b0;
      winner_q   <= '0;
      reg_off_q  <= '0;
      reg_rd_q   <= 1'b0;
      SLAVE_n    <= 1'b1;
      DTACK_n    <= 1'b1;
      DOUT       <= 8'h00;
      DOE        <= 1'b0;
    end else if (FCS_n) begin
      // Strobe released: end of cycle or abort, either way drop the bus.
      state_q <= StIdle;
      SLAVE_n <= 1'b1;
      DTACK_n <= 1'b1;
      DOUT    <= 8'h00;
      DOE     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (reg_claim) begin
            state_q   <= StReg;
            SLAVE_n   <= 1'b0;
            reg_off_q <= ADDR[3:2];
            reg_rd_q  <= READ;
          end else if (iack_hit) begin
            state_q  <= StIackPoll;
            winner_q <= win_idx;
          end
        end
        StReg: begin
          if (!DS0_n) begin
            state_q <= StAck;
            DTACK_n <= 1'b0;
            DOE     <= 1'b1;
            if (!reg_rd_q) begin
              if (reg_off_q == 2'd0) begin
                vector_q   <= DIN;
                assigned_q <= 1'b1;
              end else if (reg_off_q == 2'd1) begin
                mask_q <= DIN[NUM_SRC-1:0];
              end
            end
`ifdef ZINT_STATUS_READ_EN
            else DOUT <= rd_data;
`endif
          end
        end
        StIackPoll: begin
          if (!MTCR_n) begin
            state_q <= StIackSlv;
            SLAVE_n <= 1'b0;
          end
        end
        StIackSlv: begin
          if (!DS0_n) begin
            state_q <= StAck;
            DTACK_n <= 1'b0;
            DOE     <= 1'b1;
            DOUT    <= vector_q + {5'b0, winner_q};
          end
        end
        StAck:     state_q <= StWaitEnd;
        StWaitEnd: state_q <= StWaitEnd;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zorro_int_ctrl.sv
// Scoreboard bench for zorro_int_ctrl: directed bus cycles, acknowledge monitor checks DOUT.
module tb_zorro_int_ctrl;

  localparam logic [6:0] BASE = 7'h44;

  logic        CLK = 1'b0;
  logic        RESET_n, FCS_n, DS0_n, MTCR_n, READ, LOCK, configured;
  logic [2:0]  FC;
  logic [23:1] ADDR;
  logic [7:0]  DIN;
  logic [3:0]  SRC_INT_n;
  logic        INT_OE, SLAVE_n, DTACK_n, DOE;
  logic [7:0]  DOUT;

  zorro_int_ctrl dut (
    .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .DS0_n(DS0_n), .MTCR_n(MTCR_n),
    .READ(READ), .LOCK(LOCK), .configured(configured), .FC(FC), .ADDR(ADDR), .DIN(DIN),
    .SRC_INT_n(SRC_INT_n), .INT_OE(INT_OE), .SLAVE_n(SLAVE_n), .DTACK_n(DTACK_n),
    .DOUT(DOUT), .DOE(DOE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   doe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new acknowledge must match the oldest expected transaction.
  always @(negedge CLK) begin
    if (DOE && !doe_prev) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got DOUT %0h expected no acknowledge", DOUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_dtack"}, {31'b0, DTACK_n}, 32'd0);
        if (e.chk) check({e.name, "_dout"}, {24'b0, DOUT}, {24'b0, e.val});
      end
    end
    doe_prev = DOE;
  end

  task automatic bus_idle();
    FCS_n = 1'b1; DS0_n = 1'b1; MTCR_n = 1'b1; READ = 1'b0; LOCK = 1'b0;
    FC = 3'b001; ADDR = '0; DIN = '0;
  endtask

  task automatic access(input bit iack, input bit rd, input logic [1:0] off,
                        input logic [2:0] lvl, input logic [7:0] data, input bit exp_ack,
                        input logic [7:0] exp_dout, input bit chk, input string name);
    bit slv_seen = 1'b0;
    bit got = 1'b0;
    if (exp_ack) begin
      exp_t e;
      e.chk = chk; e.val = exp_dout; e.name = name;
      sb.push_back(e);
    end
    @(negedge CLK);
    FC    = iack ? 3'b111 : 3'b001;
    ADDR  = iack ? {20'h0, lvl} : {BASE, 13'h0, off, 1'b0};
    READ  = rd;
    DIN   = data;
    FCS_n = 1'b0;
    @(negedge CLK);
    DS0_n  = 1'b0;
    MTCR_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (!SLAVE_n) slv_seen = 1'b1;
      if (!DTACK_n) begin
        got = 1'b1;
        break;
      end
    end
    if (exp_ack) check({name, "_acked"}, {31'b0, got}, 32'd1);
    else check({name, "_unclaimed"}, {31'b0, slv_seen | got}, 32'd0);
    bus_idle();
    repeat (2) @(negedge CLK);
  endtask

  task automatic pulse_src(input logic [3:0] bits);
    @(negedge CLK);
    SRC_INT_n = ~bits;
    repeat (2) @(negedge CLK);
    SRC_INT_n = 4'hF;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    RESET_n = 1'b0; configured = 1'b1; SRC_INT_n = 4'hF;
    bus_idle();
    repeat (2) @(negedge CLK);
    check("rst_int_oe", {31'b0, INT_OE}, 32'd0);
    check("rst_slave_n", {31'b0, SLAVE_n}, 32'd1);
    check("rst_dtack_n", {31'b0, DTACK_n}, 32'd1);
    check("rst_dout", {24'b0, DOUT}, 32'h00);
    check("rst_doe", {31'b0, DOE}, 32'd0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Vector write, then source 2 raises INT within three clocks.
    access(0, 0, 2'd0, 3'd0, 8'h40, 1, 8'h00, 0, "wr_vec40");
    check("int_before_src", {31'b0, INT_OE}, 32'd0);
    SRC_INT_n[2] = 1'b0;
    repeat (3) @(negedge CLK);
    check("int_src2_3clk", {31'b0, INT_OE}, 32'd1);
    SRC_INT_n[1] = 1'b0;
    repeat (3) @(negedge CLK);
    SRC_INT_n = 4'hF;
    repeat (3) @(negedge CLK);

    // Pending {1,2}: lowest index first, then source 2.
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h41, 1, "iack_src1");
    check("int_still_src2", {31'b0, INT_OE}, 32'd1);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h42, 1, "iack_src2");
    check("int_all_clear", {31'b0, INT_OE}, 32'd0);

    // Masked source: no INT, IACK not claimed.
    pulse_src(4'b0100);
    check("int_src2_again", {31'b0, INT_OE}, 32'd1);
    access(0, 0, 2'd1, 3'd0, 8'h04, 1, 8'h00, 0, "wr_mask04");
    check("int_masked", {31'b0, INT_OE}, 32'd0);
    access(1, 1, 2'd0, 3'd2, 8'h00, 0, 8'h00, 0, "iack_masked");
    access(0, 0, 2'd1, 3'd0, 8'h00, 1, 8'h00, 0, "wr_mask00");
    check("int_unmasked", {31'b0, INT_OE}, 32'd1);

    // Abort in IACK_SLV: bus released, pending kept.
    @(negedge CLK);
    FC = 3'b111; READ = 1'b1; ADDR = {20'h0, 3'd2}; FCS_n = 1'b0; MTCR_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (!SLAVE_n) seen = 1'b1;
    end
    check("abort_reached_slv", {31'b0, seen}, 32'd1);
    FCS_n = 1'b1;
    @(negedge CLK);
    check("abort_slave_n", {31'b0, SLAVE_n}, 32'd1);
    check("abort_dtack_n", {31'b0, DTACK_n}, 32'd1);
    bus_idle();
    repeat (2) @(negedge CLK);
    check("abort_pending_kept", {31'b0, INT_OE}, 32'd1);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h42, 1, "iack_after_abort");
    check("int_clear_abort", {31'b0, INT_OE}, 32'd0);

    // Source held low through its own acknowledge stays pending.
    SRC_INT_n[0] = 1'b0;
    repeat (3) @(negedge CLK);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h40, 1, "iack_hold1");
    check("int_hold_pending", {31'b0, INT_OE}, 32'd1);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h40, 1, "iack_hold2");
    SRC_INT_n = 4'hF;
    repeat (4) @(negedge CLK);
    check("int_hold_sticky", {31'b0, INT_OE}, 32'd1);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h40, 1, "iack_hold3");
    check("int_hold_clear", {31'b0, INT_OE}, 32'd0);

    // Wrong interrupt level is ignored.
    pulse_src(4'b0010);
    access(1, 1, 2'd0, 3'd3, 8'h00, 0, 8'h00, 0, "iack_lvl3");
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h41, 1, "iack_lvl2");

    // Status read of pending 4'b0101.
    pulse_src(4'b0101);
`ifdef ZINT_STATUS_READ_EN
    access(0, 1, 2'd2, 3'd0, 8'h00, 1, 8'h05, 1, "rd_status");
    access(0, 1, 2'd0, 3'd0, 8'h00, 1, 8'h40, 1, "rd_vector");
`else
    access(0, 1, 2'd2, 3'd0, 8'h00, 0, 8'h00, 0, "rd_status");
`endif
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h40, 1, "iack_st0");
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h42, 1, "iack_st2");
    check("int_st_clear", {31'b0, INT_OE}, 32'd0);

    // Reset in the middle of a write releases the bus at once.
    @(negedge CLK);
    FC = 3'b001; ADDR = {BASE, 13'h0, 2'd0, 1'b0}; DIN = 8'h80; FCS_n = 1'b0;
    @(negedge CLK);
    check("mid_rst_claimed", {31'b0, SLAVE_n}, 32'd0);
    DS0_n = 1'b0;
    #2 RESET_n = 1'b0;
    #1;
    check("mid_rst_slave_n", {31'b0, SLAVE_n}, 32'd1);
    check("mid_rst_doe", {31'b0, DOE}, 32'd0);
    bus_idle();
    @(negedge CLK);
    RESET_n = 1'b1;
    pulse_src(4'b1000);
    check("int_unassigned", {31'b0, INT_OE}, 32'd0);
    access(0, 0, 2'd0, 3'd0, 8'h20, 1, 8'h00, 0, "wr_vec20");
    check("int_assigned", {31'b0, INT_OE}, 32'd1);
    access(1, 1, 2'd0, 3'd2, 8'h00, 1, 8'h23, 1, "iack_src3");

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_ack: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
